// File: rtl/fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// fifo_sync_flags
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds and overflow/underflow error pulses.
//
//   Optional feature macro: FIFO_FWFT_EN
//     undefined : standard mode, fifo_out registered, 1-cycle read latency
//     defined   : first-word-fall-through, fifo_out shows the head word
//                 continuously and read_en pops it
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   write_en     write request
//   fifo_in      write data
//   read_en      read request (pop in FWFT mode)
//   fifo_out     read data
//   empty        count == 0
//   full         count == DEPTH
//   almost_empty count <= AE_LEVEL
//   almost_full  count >= AF_LEVEL
//   count        words stored, 0..DEPTH
//   overflow     1-cycle pulse, write rejected because full
//   underflow    1-cycle pulse, read rejected because empty
//
// Parameter legal range: 0 < AE_LEVEL < AF_LEVEL < 2**ADDRESS_WIDTH
// ---------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned AF_LEVEL      = (2 ** ADDRESS_WIDTH) - 2,
    parameter int unsigned AE_LEVEL      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic [DATA_WIDTH-1:0]    fifo_in,
    input  logic                     read_en,
    output logic [DATA_WIDTH-1:0]    fifo_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int unsigned CW    = ADDRESS_WIDTH + 1;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;

    logic                     wr_accept_c;
    logic                     rd_accept_c;
    logic [CW-1:0]            count_next_c;

    // Accept decisions use only registered flags, never the opposite request.
    assign wr_accept_c = write_en && !full;
    assign rd_accept_c = read_en  && !empty;

    // Next occupancy; a simultaneous accepted write and read cancel out.
    always_comb begin
        count_next_c = count;
        unique case ({wr_accept_c, rd_accept_c})
            2'b10:   count_next_c = count + CW'(1);
            2'b01:   count_next_c = count - CW'(1);
            default: count_next_c = count;
        endcase
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept_c) begin
            mem[wr_ptr] <= fifo_in;
        end
    end

    // Pointers, count, flags and error pulses.
    // Flags are registered from the next count so they match a decode of
    // the registered count without any path from the request inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept_c) begin
                wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
            end
            if (rd_accept_c) begin
                rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
            end
            count        <= count_next_c;
            empty        <= (count_next_c == '0);
            full         <= (count_next_c == CW'(DEPTH));
            almost_empty <= (count_next_c <= CW'(AE_LEVEL));
            almost_full  <= (count_next_c >= CW'(AF_LEVEL));
            overflow     <= write_en && full;
            underflow    <= read_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always visible; contents are meaningless while empty.
    always_comb begin
        fifo_out = mem[rd_ptr];
    end
`else
    // Registered read port; holds its value unless a read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_out <= '0;
        end else if (rd_accept_c) begin
            fifo_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
module tb_fifo_sync_flags;

    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 14;
    localparam int unsigned AEL   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic [DW-1:0] fifo_in = '0;
    logic          read_en = 1'b0;
    logic [DW-1:0] fifo_out;
    logic          empty, full, almost_empty, almost_full;
    logic [AW:0]   count;
    logic          overflow, underflow;

    fifo_sync_flags #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .AF_LEVEL     (AFL),
        .AE_LEVEL     (AEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_en    (write_en),
        .fifo_in     (fifo_in),
        .read_en     (read_en),
        .fifo_out    (fifo_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cnt;
        logic          ov;
        logic          uf;
        logic [DW-1:0] dout;
        logic          chk_dout;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_out = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference model: the FIFO is a queue; everything follows from its size.
    task automatic cycle(input logic rst, input logic we, input logic [DW-1:0] din,
                         input logic re);
        exp_t e;
        bit   was_full, was_empty;
        @(negedge clk);
        reset    = rst;
        write_en = we;
        fifo_in  = din;
        read_en  = re;
        e.ov = 1'b0;
        e.uf = 1'b0;
        if (rst) begin
            model_q.delete();
            model_out = '0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (re && !was_empty) model_out = model_q.pop_front();
            if (we && !was_full)  model_q.push_back(din);
            e.ov = we && was_full;
            e.uf = re && was_empty;
        end
        e.cnt = model_q.size();
`ifdef FIFO_FWFT_EN
        e.chk_dout = (model_q.size() != 0);
        e.dout     = (model_q.size() != 0) ? model_q[0] : '0;
`else
        e.chk_dout = 1'b1;
        e.dout     = model_out;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per clock edge that had stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count",        32'(count),        32'(e.cnt));
                chk("empty",        32'(empty),        32'(e.cnt == 0));
                chk("full",         32'(full),         32'(e.cnt == DEPTH));
                chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= AEL));
                chk("almost_full",  32'(almost_full),  32'(e.cnt >= AFL));
                chk("overflow",     32'(overflow),     32'(e.ov));
                chk("underflow",    32'(underflow),    32'(e.uf));
                if (e.chk_dout) chk("fifo_out", 32'(fifo_out), 32'(e.dout));
            end
        end
    end

    initial begin
        logic [DW-1:0] v;
        int            wbias;

        // reset for three cycles, then idle
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // fill with 1..F,0 then one overflowing write
        for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, DW'(i), 1'b0);
        cycle(1'b0, 1'b1, 4'h5, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // write and read together while full: write rejected, read accepted
        cycle(1'b0, 1'b1, 4'h9, 1'b1);
        cycle(1'b0, 1'b1, 4'h1, 1'b0);

        // drain, then one underflowing read
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // fill to 8, then streaming write+read for 20 cycles
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, DW'($urandom), 1'b1);

        // mid-stream reset at count 5 with a pending write
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, DW'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 4'h7, 1'b0);
        cycle(1'b0, 1'b1, 4'h3, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // randomized phases with varying write/read bias and rare resets
        for (int p = 0; p < 12; p++) begin
            wbias = (p % 3 == 0) ? 85 : ((p % 3 == 1) ? 15 : 50);
            for (int i = 0; i < 60; i++) begin
                v = DW'($urandom);
                cycle(($urandom_range(0, 99) == 0),
                      ($urandom_range(0, 99) < wbias),
                      v,
                      ($urandom_range(0, 99) < (100 - wbias)));
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);

        // bounded wait for the monitor to consume every expectation
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
